bus_master_arbiter: RTL and testbench

//  68000 bus-arbitration controller; replaces the constant BR tie-off at top level.

---
 rtl/bus_master_arbiter_if.sv | 39 +++
 rtl/bus_master_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_bus_master_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_arbiter_if.sv
// Bus-arbitration signal bundle between the 68000 arbiter and its environment.
// slave: arbiter side (requests/CPU status in, BR/BGACK/GRANT out); master: environment side.
interface bus_master_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic               RUN_IN;
    logic [NUM_REQ-1:0] REQ_IN;
    logic               BG_IN;
    logic               AS_IN;
    logic               DTACK_IN;
    logic               BR;
    logic               BGACK;
    logic [NUM_REQ-1:0] GRANT;
    logic               TIMEOUT_ERR;

    modport slave (
        input  RUN_IN,
        input  REQ_IN,
        input  BG_IN,
        input  AS_IN,
        input  DTACK_IN,
        output BR,
        output BGACK,
        output GRANT,
        output TIMEOUT_ERR
    );

    modport master (
        output RUN_IN,
        output REQ_IN,
        output BG_IN,
        output AS_IN,
        output DTACK_IN,
        input  BR,
        input  BGACK,
        input  GRANT,
        input  TIMEOUT_ERR
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// 68000 bus-arbitration controller: shares the CPU bus among NUM_REQ DMA requesters.
// Ports: MCLK_IN, RESET_ALL_N_IN (async, active-low), bus (slave modport: RUN_IN,
// REQ_IN, BG_IN, AS_IN, DTACK_IN in; BR, BGACK, GRANT, TIMEOUT_ERR out).
// Optional BG timeout: define BUS_ARB_TIMEOUT_EN.
module bus_master_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_HOLD    = 255,
    parameter int BG_TIMEOUT  = 1023
) (
    input  logic                MCLK_IN,
    input  logic                RESET_ALL_N_IN,
    bus_master_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be 1..8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("MAX_HOLD must be 1..65535");
    end
    if (BG_TIMEOUT < 1) begin : g_bad_timeout
        $error("BG_TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_FREE,
        OWN,
        RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]          win_q, win_d;
    logic [PW-1:0]          rr_q, rr_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   br_q, br_d;
    logic                   bgack_q, bgack_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [SYNC_STAGES-1:0] bg_sync, as_sync;
    logic                   bg_s, as_s;
    logic                   any_req, owner_req, bus_free;
    logic [PW-1:0]          pick_win, rr_next;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int WW = $clog2(BG_TIMEOUT + 1);
    logic [WW-1:0] wait_q, wait_d;
    logic          terr_q, terr_d;
    logic          timed_out;
    assign timed_out = (wait_q == WW'(BG_TIMEOUT - 1));
`endif

    function automatic logic [NUM_REQ-1:0] to_oh(input logic [PW-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        for (int j = 0; j < NUM_REQ; j++) begin
            oh[j] = (idx == PW'(j));
        end
        return oh;
    endfunction

    // Round-robin: lowest set request at/after ptr, else wrap to lowest set.
    // Scanning downward leaves the lowest qualifying index in each result.
    function automatic logic [PW-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [PW-1:0]      ptr
    );
        logic [PW-1:0] hi, lo;
        logic          hit;
        hi  = '0;
        lo  = '0;
        hit = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo = PW'(j);
                if (PW'(j) >= ptr) begin
                    hi  = PW'(j);
                    hit = 1'b1;
                end
            end
        end
        return hit ? hi : lo;
    endfunction

    // BG and AS come straight from the CPU pins.
    always_ff @(posedge MCLK_IN or negedge RESET_ALL_N_IN) begin
        if (!RESET_ALL_N_IN) begin
            bg_sync <= '0;
            as_sync <= '0;
        end else begin
            bg_sync <= {bg_sync[SYNC_STAGES-2:0], bus.BG_IN};
            as_sync <= {as_sync[SYNC_STAGES-2:0], bus.AS_IN};
        end
    end

    assign bg_s      = bg_sync[SYNC_STAGES-1];
    assign as_s      = as_sync[SYNC_STAGES-1];
    assign any_req   = |bus.REQ_IN;
    assign owner_req = |(bus.REQ_IN & to_oh(win_q));
    assign bus_free  = !as_s && !bus.DTACK_IN;
    assign pick_win  = rr_pick(bus.REQ_IN, rr_q);
    assign rr_next   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
`ifdef BUS_ARB_TIMEOUT_EN
        wait_d  = wait_q;
        terr_d  = 1'b0;
`endif
        if (!bus.RUN_IN) begin
            // CPU is held in reset, so the bus is simply dropped.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d = REQUEST;
                        win_d   = pick_win;
`ifdef BUS_ARB_TIMEOUT_EN
                        wait_d  = '0;
`endif
                    end
                end
                REQUEST: begin
                    if (!owner_req && !any_req) begin
                        state_d = IDLE;
                    end else begin
                        if (!owner_req) begin
                            win_d = pick_win;
                        end
                        if (bg_s) begin
                            state_d = WAIT_FREE;
                        end
`ifdef BUS_ARB_TIMEOUT_EN
                        else if (timed_out) begin
                            state_d = IDLE;
                            terr_d  = 1'b1;
                            rr_d    = rr_next;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
`endif
                    end
                end
                WAIT_FREE: begin
                    // Losing BG here is ignored; the CPU has already
                    // committed to releasing the bus.
                    if (!owner_req && !any_req) begin
                        state_d = IDLE;
                    end else begin
                        if (!owner_req) begin
                            win_d = pick_win;
                        end
                        if (bus_free) begin
                            state_d = OWN;
                            hold_d  = '0;
                        end
                    end
                end
                OWN: begin
                    if (hold_q != HW'(MAX_HOLD)) begin
                        hold_d = hold_q + 1'b1;
                    end
                    if (!owner_req || hold_q == HW'(MAX_HOLD - 1)) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    state_d = IDLE;
                    rr_d    = rr_next;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs follow the next state so they come straight off flops.
        br_d    = (state_d == REQUEST) || (state_d == WAIT_FREE);
        bgack_d = (state_d == OWN) || (state_d == RELEASE);
        grant_d = (state_d == OWN) ? to_oh(win_d) : '0;
    end

    always_ff @(posedge MCLK_IN or negedge RESET_ALL_N_IN) begin
        if (!RESET_ALL_N_IN) begin
            state_q <= IDLE;
            win_q   <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            br_q    <= 1'b0;
            bgack_q <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            br_q    <= br_d;
            bgack_q <= bgack_d;
            grant_q <= grant_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge MCLK_IN or negedge RESET_ALL_N_IN) begin
        if (!RESET_ALL_N_IN) begin
            wait_q <= '0;
            terr_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            terr_q <= terr_d;
        end
    end

    assign bus.TIMEOUT_ERR = terr_q;
`else
    assign bus.TIMEOUT_ERR = 1'b0;
`endif

    assign bus.BR    = br_q;
    assign bus.BGACK = bgack_q;
    assign bus.GRANT = grant_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter.
// Observes {BR, BGACK, GRANT} one time unit after each rising edge.
module tb_bus_master_arbiter;
    localparam int NR = 2;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    bus_master_arbiter_if #(.NUM_REQ(NR)) bus ();

    bus_master_arbiter #(
        .NUM_REQ    (NR),
        .SYNC_STAGES(2),
        .MAX_HOLD   (4),
        .BG_TIMEOUT (16)
    ) dut (
        .MCLK_IN       (clk),
        .RESET_ALL_N_IN(rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] obs;
    assign obs = {bus.BR, bus.BGACK, bus.GRANT};

    logic [3:0] t3_exp [0:18];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] o,
                       input logic [7:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got %b want %b", tag, o, e);
        end
    endtask

    initial begin
        t3_exp = '{4'b1000, 4'b1000, 4'b0101, 4'b0101, 4'b0101,
                   4'b0101, 4'b0100, 4'b0000, 4'b1000, 4'b1000,
                   4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100,
                   4'b0000, 4'b1000, 4'b1000, 4'b0101};

        rst_n        = 1'b0;
        bus.RUN_IN   = 1'b0;
        bus.REQ_IN   = '0;
        bus.BG_IN    = 1'b0;
        bus.AS_IN    = 1'b0;
        bus.DTACK_IN = 1'b0;
        step(2);
        chk("reset_outs", 8'(obs), 8'b0000);
        chk("reset_terr", 8'(bus.TIMEOUT_ERR), 8'd0);
        rst_n      = 1'b1;
        bus.RUN_IN = 1'b1;
        step(2);
        chk("idle_no_req", 8'(obs), 8'b0000);

        // Single requester, BG three cycles after BR.
        bus.REQ_IN = 2'b01;
        step(1);
        chk("t2_br_rise", 8'(obs), 8'b1000);
        step(3);
        chk("t2_br_wait", 8'(obs), 8'b1000);
        bus.BG_IN = 1'b1;
        step(3);
        chk("t2_pre_own", 8'(obs), 8'b1000);
        step(1);
        chk("t2_own", 8'(obs), 8'b0101);
        bus.REQ_IN = 2'b00;
        step(1);
        chk("t2_release", 8'(obs), 8'b0100);
        bus.BG_IN = 1'b0;
        step(1);
        chk("t2_idle", 8'(obs), 8'b0000);

        // AS held high keeps the arbiter in WAIT_FREE.
        bus.BG_IN = 1'b1;
        bus.AS_IN = 1'b1;
        step(3);
        bus.REQ_IN = 2'b01;
        step(1);
        chk("t4_request", 8'(obs), 8'b1000);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_as_busy", 8'(obs), 8'b1000);
        end
        bus.AS_IN = 1'b0;
        step(2);
        chk("t4_as_sync", 8'(obs), 8'b1000);
        step(1);
        chk("t4_own", 8'(obs), 8'b0101);
        bus.REQ_IN = 2'b00;
        step(1);
        chk("t4_release", 8'(obs), 8'b0100);
        step(1);
        chk("t4_idle", 8'(obs), 8'b0000);

        // Asynchronous reset in the middle of a tenure.
        bus.REQ_IN = 2'b10;
        step(3);
        chk("t1_own_rr", 8'(obs), 8'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_rst", 8'(obs), 8'b0000);
        step(1);
        chk("t1_in_rst", 8'(obs), 8'b0000);
        bus.REQ_IN = 2'b00;
        rst_n      = 1'b1;
        step(1);
        chk("t1_idle_after", 8'(obs), 8'b0000);
        step(3);

        // Both requesting continuously: hold limit and alternation.
        bus.REQ_IN = 2'b11;
        for (int i = 0; i < 19; i++) begin
            step(1);
            chk($sformatf("t3_cyc%0d", i + 1), 8'(obs), 8'(t3_exp[i]));
        end
        bus.REQ_IN = 2'b00;
        step(1);
        chk("t3_release", 8'(obs), 8'b0100);
        step(1);
        chk("t3_idle", 8'(obs), 8'b0000);

        // DTACK blocks ownership; RUN_IN drop aborts with no RELEASE.
        bus.DTACK_IN = 1'b1;
        bus.REQ_IN   = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t5_dtack_busy", 8'(obs), 8'b1000);
        end
        bus.DTACK_IN = 1'b0;
        step(1);
        chk("t5_own", 8'(obs), 8'b0110);
        bus.RUN_IN = 1'b0;
        step(1);
        chk("t5_run_drop", 8'(obs), 8'b0000);
        step(1);
        chk("t5_run_low", 8'(obs), 8'b0000);
        bus.RUN_IN = 1'b1;
        step(1);
        chk("t5_run_back", 8'(obs), 8'b1000);
        bus.REQ_IN = 2'b00;
        step(1);
        chk("t5_drop_idle", 8'(obs), 8'b0000);

        // Owner drops in REQUEST while the other requests: re-arbitrate.
        bus.BG_IN = 1'b0;
        step(3);
        bus.REQ_IN = 2'b01;
        step(1);
        chk("rearb_req", 8'(obs), 8'b1000);
        bus.REQ_IN = 2'b10;
        step(1);
        chk("rearb_stay", 8'(obs), 8'b1000);
        bus.BG_IN = 1'b1;
        step(3);
        chk("rearb_wait", 8'(obs), 8'b1000);
        step(1);
        chk("rearb_own", 8'(obs), 8'b0110);
        bus.REQ_IN = 2'b00;
        step(1);
        chk("rearb_release", 8'(obs), 8'b0100);
        step(1);
        chk("rearb_idle", 8'(obs), 8'b0000);

        // BG never arrives.
        bus.BG_IN = 1'b0;
        step(3);
        bus.REQ_IN = 2'b01;
        for (int i = 1; i <= 18; i++) begin
            logic [1:0] e;
            step(1);
            if (TO_EN) e = (i == 17) ? 2'b01 : 2'b10;
            else       e = 2'b10;
            chk($sformatf("t6_cyc%0d", i),
                8'({bus.BR, bus.TIMEOUT_ERR}), 8'(e));
        end
        bus.REQ_IN = 2'b00;
        step(2);
        chk("t6_idle", 8'(obs), 8'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule
